// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit CPU: drives IR load select and
// datapath strobes, runs memory handshakes with a wait timeout, traps illegal groups.
module ctrl_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [5:0]  GRP_NOP     = 6'h00,
  parameter logic [5:0]  GRP_ARITH1  = 6'h01,
  parameter logic [5:0]  GRP_ARITH2  = 6'h02,
  parameter logic [5:0]  GRP_GETREG  = 6'h03,
  parameter logic [5:0]  GRP_SETREG  = 6'h04,
  parameter logic [5:0]  GRP_LOAD    = 6'h05,
  parameter logic [5:0]  GRP_STORE   = 6'h06,
  parameter logic [5:0]  GRP_JUMP    = 6'h07,
  parameter logic [5:0]  GRP_HALT    = 6'h08,
  parameter logic [5:0]  GRP_IMM     = 6'h3F,
  parameter logic [4:0]  SEL_NONE    = 5'd0,
  parameter logic [4:0]  SEL_ZERO    = 5'd1,
  parameter logic [4:0]  SEL_MEM     = 5'd2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  OpGrp,
  input  logic        MemReady,
  input  logic        Resume,
  output logic [4:0]  SrcIR,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AddrSel,
  output logic        PCInc,
  output logic        PCLoad,
  output logic        AccLoad,
  output logic        RegWrite,
  output logic        ImmLoad,
  output logic [2:0]  State,
  output logic [15:0] InstrCount,
  output logic        IllegalOp,
  output logic        BusErr
);

  localparam int unsigned   CW     = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] K_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t        state, stateNext;
  logic [5:0]    grp;
  logic [CW-1:0] waitCnt;
  logic          timeout, cntInc, setIllegal, setBusErr;

  assign timeout = !MemReady && (waitCnt == K_LAST);
  assign State   = state;

  always_comb begin
    stateNext  = state;
    SrcIR      = SEL_NONE;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AddrSel    = 1'b0;
    PCInc      = 1'b0;
    PCLoad     = 1'b0;
    AccLoad    = 1'b0;
    RegWrite   = 1'b0;
    ImmLoad    = 1'b0;
    cntInc     = 1'b0;
    setIllegal = 1'b0;
    setBusErr  = 1'b0;
    case (state)
      ST_RESET: begin
        SrcIR     = SEL_ZERO;
        stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          SrcIR     = SEL_MEM;
          PCInc     = 1'b1;
          stateNext = ST_DECODE;
        end else if (timeout) begin
          setBusErr = 1'b1;
          stateNext = ST_HALT;
        end
      end
      ST_DECODE: stateNext = ST_EXEC;
      ST_EXEC: begin
        cntInc    = 1'b1;
        stateNext = ST_FETCH;
        case (grp)
          GRP_NOP: ;
          GRP_ARITH1, GRP_ARITH2, GRP_GETREG: AccLoad = 1'b1;
          GRP_SETREG: RegWrite = 1'b1;
          GRP_IMM:    ImmLoad  = 1'b1;
          GRP_JUMP:   PCLoad   = 1'b1;
          GRP_LOAD, GRP_STORE: stateNext = ST_MEM;
          GRP_HALT:   stateNext = ST_HALT;
          default: begin
            // Illegal groups are not retired.
            cntInc     = 1'b0;
            setIllegal = 1'b1;
            stateNext  = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        AddrSel  = 1'b1;
        MemRead  = (grp == GRP_LOAD);
        MemWrite = (grp == GRP_STORE);
        if (MemReady) begin
          AccLoad   = (grp == GRP_LOAD);
          stateNext = ST_FETCH;
        end else if (timeout) begin
          setBusErr = 1'b1;
          stateNext = ST_HALT;
        end
      end
      ST_HALT: begin
        if (Resume && !IllegalOp && !BusErr) stateNext = ST_FETCH;
      end
      default: stateNext = ST_RESET;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_RESET;
      grp        <= GRP_NOP;
      waitCnt    <= '0;
      InstrCount <= '0;
      IllegalOp  <= 1'b0;
      BusErr     <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == ST_DECODE) grp <= OpGrp;
      // Wait counter restarts on every state change, so it is zero on entry.
      if (stateNext != state)
        waitCnt <= '0;
      else if (!MemReady && (state == ST_FETCH || state == ST_MEM))
        waitCnt <= waitCnt + CW'(1);
      if (cntInc)     InstrCount <= InstrCount + 16'd1;
      if (setIllegal) IllegalOp  <= 1'b1;
      if (setBusErr)  BusErr     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_ctrl_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [5:0]  OpGrp = 6'h00;
  logic        MemReady = 1'b0;
  logic        Resume = 1'b0;
  logic [4:0]  SrcIR;
  logic        MemRead, MemWrite, AddrSel, PCInc, PCLoad, AccLoad, RegWrite, ImmLoad;
  logic [2:0]  State;
  logic [15:0] InstrCount;
  logic        IllegalOp, BusErr;

  ctrl_sequencer #(.MEM_TIMEOUT(16)) dut (
    .Clk(Clk), .Rst(Rst), .OpGrp(OpGrp), .MemReady(MemReady), .Resume(Resume),
    .SrcIR(SrcIR), .MemRead(MemRead), .MemWrite(MemWrite), .AddrSel(AddrSel),
    .PCInc(PCInc), .PCLoad(PCLoad), .AccLoad(AccLoad), .RegWrite(RegWrite),
    .ImmLoad(ImmLoad), .State(State), .InstrCount(InstrCount),
    .IllegalOp(IllegalOp), .BusErr(BusErr)
  );

  always #5 Clk = ~Clk;

  localparam logic [2:0] RST = 3'd0, FET = 3'd1, DEC = 3'd2, EXE = 3'd3, MEMS = 3'd4, HLT = 3'd5;
  localparam logic [4:0] SN = 5'd0, SZ = 5'd1, SM = 5'd2;
  // Strobe bits: MemRead MemWrite AddrSel PCInc PCLoad AccLoad RegWrite ImmLoad
  localparam logic [7:0] S_NONE    = 8'b0000_0000;
  localparam logic [7:0] S_FETW    = 8'b1000_0000;
  localparam logic [7:0] S_FETOK   = 8'b1001_0000;
  localparam logic [7:0] S_PCL     = 8'b0000_1000;
  localparam logic [7:0] S_ACC     = 8'b0000_0100;
  localparam logic [7:0] S_REG     = 8'b0000_0010;
  localparam logic [7:0] S_IMM     = 8'b0000_0001;
  localparam logic [7:0] S_MEMRD   = 8'b1010_0000;
  localparam logic [7:0] S_MEMRDOK = 8'b1010_0100;
  localparam logic [7:0] S_MEMWR   = 8'b0110_0000;

  logic [33:0] expQ[$];
  string       nameQ[$];
  int          tests = 0;
  int          failed = 0;
  logic [15:0] expCnt = 16'd0;
  logic        expIll = 1'b0;
  logic        expBus = 1'b0;

  // Monitor: one expectation per clock cycle, checked mid-cycle.
  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      logic [33:0] e, a;
      string nm;
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      a  = {State, SrcIR, MemRead, MemWrite, AddrSel, PCInc, PCLoad, AccLoad,
            RegWrite, ImmLoad, InstrCount, IllegalOp, BusErr};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL %s: got st=%0d src=%0d stb=%b cnt=%0d ill=%b bus=%b, expected st=%0d src=%0d stb=%b cnt=%0d ill=%b bus=%b",
                 nm, a[33:31], a[30:26], a[25:18], a[17:2], a[1], a[0],
                 e[33:31], e[30:26], e[25:18], e[17:2], e[1], e[0]);
      end
    end
  end

  task automatic push(input logic [2:0] st, input logic [4:0] src, input logic [7:0] stb,
                      input string nm);
    expQ.push_back({st, src, stb, expCnt, expIll, expBus});
    nameQ.push_back(nm);
  endtask

  task automatic cyc(input logic rdy, input logic res, input logic [2:0] st,
                     input logic [4:0] src, input logic [7:0] stb, input string nm);
    @(posedge Clk);
    #1;
    MemReady = rdy;
    Resume   = res;
    push(st, src, stb, nm);
  endtask

  task automatic instr(input logic [5:0] op, input logic [7:0] stb, input int unsigned waits,
                       input logic legal, input string nm);
    OpGrp = op;
    for (int unsigned i = 0; i < waits; i++) cyc(1'b0, 1'b0, FET, SN, S_FETW, {nm, "_fwait"});
    cyc(1'b1, 1'b0, FET, SM, S_FETOK, {nm, "_fetch"});
    cyc(1'b1, 1'b0, DEC, SN, S_NONE, {nm, "_decode"});
    cyc(1'b1, 1'b0, EXE, SN, stb, {nm, "_exec"});
    if (legal) expCnt = expCnt + 16'd1;
    else expIll = 1'b1;
  endtask

  task automatic doReset(input string nm);
    @(posedge Clk);
    #1;
    Rst = 1'b1; MemReady = 1'b0; Resume = 1'b0;
    expCnt = 16'd0; expIll = 1'b0; expBus = 1'b0;
    push(RST, SZ, S_NONE, {nm, "_assert"});
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, {nm, "_hold"});
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, {nm, "_release"});
    Rst = 1'b0;
  endtask

  initial begin
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, "rst0");
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, "rst1");
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, "rst2");
    Rst = 1'b0;

    instr(6'h00, S_NONE, 0, 1'b1, "nop");
    instr(6'h3F, S_IMM,  0, 1'b1, "imm");
    instr(6'h01, S_ACC,  0, 1'b1, "arith1");
    instr(6'h02, S_ACC,  0, 1'b1, "arith2");
    instr(6'h03, S_ACC,  0, 1'b1, "getreg");
    instr(6'h04, S_REG,  0, 1'b1, "setreg");
    instr(6'h07, S_PCL,  0, 1'b1, "jump");

    instr(6'h05, S_NONE, 0, 1'b1, "load");
    for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b0, MEMS, SN, S_MEMRD, "load_wait");
    cyc(1'b1, 1'b0, MEMS, SN, S_MEMRDOK, "load_done");

    instr(6'h06, S_NONE, 0, 1'b1, "store");
    cyc(1'b1, 1'b0, MEMS, SN, S_MEMWR, "store_done");

    // Fetch never answered: the 16th waiting cycle raises BusErr.
    for (int unsigned i = 0; i < 16; i++) cyc(1'b0, 1'b0, FET, SN, S_FETW, "fto_wait");
    expBus = 1'b1;
    cyc(1'b0, 1'b1, HLT, SN, S_NONE, "fto_halt");
    cyc(1'b0, 1'b1, HLT, SN, S_NONE, "fto_resume_ignored");

    doReset("rstA");
    instr(6'h00, S_NONE, 15, 1'b1, "late_ready");

    instr(6'h20, S_NONE, 0, 1'b0, "illegal");
    cyc(1'b0, 1'b1, HLT, SN, S_NONE, "ill_halt");
    cyc(1'b0, 1'b1, HLT, SN, S_NONE, "ill_resume_ignored");

    doReset("rstB");
    instr(6'h08, S_NONE, 0, 1'b1, "halt");
    cyc(1'b0, 1'b0, HLT, SN, S_NONE, "halt_wait");
    cyc(1'b0, 1'b1, HLT, SN, S_NONE, "halt_resume");
    instr(6'h00, S_NONE, 0, 1'b1, "post_resume");

    // Reset raised between clock edges while a store is waiting.
    instr(6'h06, S_NONE, 0, 1'b1, "st2");
    cyc(1'b0, 1'b0, MEMS, SN, S_MEMWR, "st2_wait");
    @(posedge Clk);
    #1;
    MemReady = 1'b0;
    #2;
    Rst = 1'b1;
    expCnt = 16'd0; expIll = 1'b0; expBus = 1'b0;
    push(RST, SZ, S_NONE, "async_rst");
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, "async_hold");
    cyc(1'b0, 1'b0, RST, SZ, S_NONE, "async_release");
    Rst = 1'b0;
    instr(6'h3F, S_IMM, 0, 1'b1, "post_async");
    cyc(1'b1, 1'b0, FET, SM, S_FETOK, "final_fetch");

    @(negedge Clk);
    #1;
    if (expQ.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Fetch/decode/execute control FSM for the 16-bit CPU.
- Drives the instruction-register load select (SrcIR) of the decoder and all datapath strobes: PC, accumulator, register file, immediate, memory.
- Consumes the decoder's OpGrp, runs memory transactions with a ready handshake and timeout, and traps illegal groups into HALT.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for MemReady per transaction (>=2)
GRP_NOP, 6'h00, no-op group
GRP_ARITH1, 6'h01, ALU group 1
GRP_ARITH2, 6'h02, ALU group 2
GRP_GETREG, 6'h03, register -> accumulator
GRP_SETREG, 6'h04, accumulator -> register
GRP_LOAD, 6'h05, memory -> accumulator
GRP_STORE, 6'h06, accumulator -> memory
GRP_JUMP, 6'h07, load PC
GRP_HALT, 6'h08, stop
GRP_IMM, 6'h3F, immediate load
SEL_NONE / SEL_ZERO / SEL_MEM, 5'd0 / 5'd1 / 5'd2, SrcIR encodings

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
OpGrp  in  6  decoded op group; valid from the cycle after IR load
MemReady  in  1  memory completes current read/write this cycle
Resume  in  1  leave HALT when no error flag is set
SrcIR  out  5  IR load select to the decoder
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
AddrSel  out  1  0 = PC address, 1 = operand address
PCInc  out  1  PC += 1
PCLoad  out  1  PC <= jump target
AccLoad  out  1  accumulator load strobe
RegWrite  out  1  register file write strobe
ImmLoad  out  1  immediate -> accumulator strobe
State  out  3  0 RESET, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 HALT
InstrCount  out  16  retired instructions, wraps at 16'hFFFF -> 0
IllegalOp  out  1  sticky; cleared only by Rst
BusErr  out  1  sticky; cleared only by Rst

Behaviour:
- Rst high: State=RESET, InstrCount=0, IllegalOp=0, BusErr=0, wait counter=0. Takes effect immediately, even mid-transaction.
- Strobes are a combinational function of State, the latched group register, MemReady and the wait counter. Strobes are 0 unless stated below. SrcIR=SEL_NONE unless stated below.
- RESET: SrcIR=SEL_ZERO, which clears the IR to NOP. Next state FETCH.
- FETCH: MemRead=1, AddrSel=0.
  - MemReady=1: SrcIR=SEL_MEM and PCInc=1 in the same cycle; next state DECODE.
- DECODE: latch OpGrp into the group register. Next state EXEC.
- EXEC: lasts one cycle; InstrCount += 1 unless the group is illegal. Per group:
  - NOP: no strobe; next FETCH.
  - ARITH1/ARITH2/GETREG: AccLoad=1; next FETCH.
  - SETREG: RegWrite=1; next FETCH.
  - IMM: ImmLoad=1; next FETCH.
  - JUMP: PCLoad=1; next FETCH.
  - LOAD/STORE: next MEM.
  - HALT: next HALT.
  - Any other group: IllegalOp<=1; next HALT.
- MEM: AddrSel=1; MemRead=1 for LOAD, MemWrite=1 for STORE.
  - On MemReady: AccLoad=1 for LOAD; next FETCH.
- Wait timeout (FETCH and MEM):
  - Counter k is 0 on state entry and increments each cycle MemReady=0.
  - MemReady=1 at any k is accepted, including k=MEM_TIMEOUT-1.
  - MemReady=0 at k=MEM_TIMEOUT-1: BusErr<=1, next HALT. Strobes stay as for the waiting state in that cycle; no completion strobe is issued.
- HALT: all strobes 0.
  - Resume=1 and IllegalOp=0 and BusErr=0: next FETCH.
  - Otherwise remain in HALT.
- Latency with MemReady tied high: 3 cycles per non-memory instruction (FETCH, DECODE, EXEC); 4 cycles for LOAD/STORE.
- At most one of PCInc/PCLoad/AccLoad/RegWrite/ImmLoad is high in any cycle; MemRead and MemWrite are never high together.

Test Plan:
- Rst pulse, memory returns 16'h0000, MemReady=1 -> State 0,1,2,3,1; SrcIR=SEL_ZERO in RESET and SEL_MEM in FETCH; one PCInc pulse; InstrCount=1.
- Fetch 16'h8005 (OpGrp=6'h3F) -> ImmLoad high exactly one cycle in EXEC; no other strobe; back to FETCH.
- LOAD with MemReady low 3 cycles in MEM -> MemRead=1 and AddrSel=1 for 4 cycles; AccLoad only on 4th; then FETCH.
- FETCH with MemReady held 0 -> BusErr=1 after 16 cycles, State=5, no PCInc; Resume=1 ignored. Repeat with MemReady at k=15 -> accepted, no error.
- OpGrp=6'h20 -> IllegalOp=1, HALT, InstrCount unchanged. Separately, GRP_HALT -> HALT; Resume=1 -> FETCH; InstrCount incremented once for the HALT instruction.
- Assert Rst asynchronously mid-MEM during STORE -> MemWrite drops without waiting for a clock edge; State=0, counters and flags 0.
